// File: rtl/mcif_rd_wrr_arb_pkg.sv
// Shared sizes, client indices and helpers for the MCIF read weighted round-robin arbiter.
package mcif_arb_pkg;

  localparam int NUM_CLIENTS = 10;
  localparam int PD_W        = 79;
  localparam int OS_W        = 8;
  localparam int ID_W        = 4;
  localparam int WT_W        = 8;

  typedef logic [ID_W-1:0] client_id_t;

  localparam client_id_t BDMA     = 4'd0;
  localparam client_id_t SDP      = 4'd1;
  localparam client_id_t PDP      = 4'd2;
  localparam client_id_t CDP      = 4'd3;
  localparam client_id_t SDP_B    = 4'd4;
  localparam client_id_t SDP_N    = 4'd5;
  localparam client_id_t SDP_E    = 4'd6;
  localparam client_id_t CDMA_DAT = 4'd7;
  localparam client_id_t CDMA_WT  = 4'd8;
  localparam client_id_t RBK      = 4'd9;

  // A zero weight still buys one grant per round so no client starves.
  function automatic logic [WT_W-1:0] clamp_weight(input logic [WT_W-1:0] w);
    logic [WT_W-1:0] r;
    if (w == '0) begin
      r = WT_W'(1);
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcif_rd_wrr_arb_rr_pick.sv
// Rotating-priority picker: first eligible client at or above rr_ptr, wrapping at the last client.
module mcif_rr_pick
  import mcif_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] elig_i,
  input  client_id_t             rr_ptr_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output client_id_t             win_o,
  output logic                   any_o
);

  typedef logic [ID_W:0] idx_ext_t;

  idx_ext_t idx_s;

  // Scan the clients in rotated order and latch onto the first eligible one.
  always_comb begin
    gnt_o = '0;
    win_o = BDMA;
    any_o = 1'b0;
    idx_s = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx_s = idx_ext_t'(rr_ptr_i) + idx_ext_t'(k);
      if (idx_s >= idx_ext_t'(NUM_CLIENTS)) begin
        idx_s = idx_s - idx_ext_t'(NUM_CLIENTS);
      end else begin
        idx_s = idx_s;
      end
      if (!any_o && elig_i[idx_s[ID_W-1:0]]) begin
        any_o                    = 1'b1;
        win_o                    = idx_s[ID_W-1:0];
        gnt_o[idx_s[ID_W-1:0]]   = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mcif_rd_wrr_arb.sv
// MCIF read-request arbiter: weighted round-robin over per-client credits, outstanding-read
// limiting and a single-register output stage toward the memory interface.
module mcif_rd_wrr_arb
  import mcif_arb_pkg::*;
(
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic [NUM_CLIENTS-1:0]      req_valid_i,
  output logic [NUM_CLIENTS-1:0]      req_ready_o,
  input  logic [NUM_CLIENTS*PD_W-1:0] req_pd_i,
  input  logic [NUM_CLIENTS*WT_W-1:0] rd_weight_i,
  input  logic [OS_W-1:0]             rd_os_cnt_i,
  output logic                        arb_valid_o,
  input  logic                        arb_ready_i,
  output logic [PD_W-1:0]             arb_pd_o,
  output client_id_t                  arb_id_o,
  input  logic                        rsp_done_i,
  output logic [OS_W-1:0]             os_inflight_o,
  output logic                        idle_o
);

  logic [WT_W-1:0]        credit_q [NUM_CLIENTS];
  logic [WT_W-1:0]        credit_d [NUM_CLIENTS];
  client_id_t             rr_ptr_q, rr_ptr_d;
  logic                   arb_valid_q, arb_valid_d;
  logic [PD_W-1:0]        arb_pd_q, arb_pd_d;
  client_id_t             arb_id_q, arb_id_d;
  logic [OS_W-1:0]        os_q, os_d;
  logic                   idle_q, idle_d;

  logic [NUM_CLIENTS-1:0] elig_s;
  logic [NUM_CLIENTS-1:0] gnt_s;
  client_id_t             win_s;
  logic                   any_s;
  logic                   can_load_s;
  logic                   grant_s;
  logic                   reload_s;

  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig_s[i] = req_valid_i[i] && (credit_q[i] != '0);
    end
  end

  mcif_rr_pick u_pick (
    .elig_i   (elig_s),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt_s),
    .win_o    (win_s),
    .any_o    (any_s)
  );

  // The output register refills in the same cycle it hands off, so back-to-back grants have no bubble.
  assign can_load_s  = !arb_valid_q || arb_ready_i;
  assign grant_s     = can_load_s && (os_q < rd_os_cnt_i) && any_s;
  assign reload_s    = (|req_valid_i) && !any_s;
  assign req_ready_o = grant_s ? gnt_s : '0;

  // Weights are sampled only on reload, so CSB writes land at the next round boundary.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      credit_d[i] = credit_q[i];
    end
    if (reload_s) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        credit_d[i] = clamp_weight(rd_weight_i[i*WT_W +: WT_W]);
      end
    end else if (grant_s) begin
      credit_d[win_s] = credit_q[win_s] - WT_W'(1);
    end else begin
      credit_d[0] = credit_q[0];
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    arb_valid_d = arb_valid_q;
    arb_pd_d    = arb_pd_q;
    arb_id_d    = arb_id_q;
    if (grant_s) begin
      rr_ptr_d    = (win_s == RBK) ? BDMA : (win_s + client_id_t'(1));
      arb_valid_d = 1'b1;
      arb_pd_d    = req_pd_i[int'(win_s)*PD_W +: PD_W];
      arb_id_d    = win_s;
    end else if (arb_ready_i) begin
      arb_valid_d = 1'b0;
    end else begin
      arb_valid_d = arb_valid_q;
    end
  end

  // A grant never pushes the count past rd_os_cnt, so only the decrement needs a floor.
  always_comb begin
    os_d = os_q;
    if (grant_s && !rsp_done_i) begin
      os_d = os_q + OS_W'(1);
    end else if (!grant_s && rsp_done_i && (os_q != '0)) begin
      os_d = os_q - OS_W'(1);
    end else begin
      os_d = os_q;
    end
  end

  assign idle_d = (os_q == '0) && !arb_valid_q && (req_valid_i == '0);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        credit_q[i] <= '0;
      end
      rr_ptr_q    <= BDMA;
      arb_valid_q <= 1'b0;
      arb_pd_q    <= '0;
      arb_id_q    <= BDMA;
      os_q        <= '0;
      idle_q      <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        credit_q[i] <= credit_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      arb_valid_q <= arb_valid_d;
      arb_pd_q    <= arb_pd_d;
      arb_id_q    <= arb_id_d;
      os_q        <= os_d;
      idle_q      <= idle_d;
    end
  end

  assign arb_valid_o   = arb_valid_q;
  assign arb_pd_o      = arb_pd_q;
  assign arb_id_o      = arb_id_q;
  assign os_inflight_o = os_q;
  assign idle_o        = idle_q;

endmodule

// File: tb/tb_mcif_rd_wrr_arb.sv
// Bench for mcif_rd_wrr_arb: directed scenarios plus randomized traffic against a
// rule-level reference model, with a scoreboard queue checked at each downstream handshake.
module tb_mcif_rd_wrr_arb;
  import mcif_arb_pkg::*;

  logic                        nvdla_core_clk = 1'b0;
  logic                        nvdla_core_rstn = 1'b0;
  logic [NUM_CLIENTS-1:0]      req_valid = '0;
  logic [NUM_CLIENTS-1:0]      req_ready;
  logic [NUM_CLIENTS*PD_W-1:0] req_pd = '0;
  logic [NUM_CLIENTS*WT_W-1:0] rd_weight = '0;
  logic [OS_W-1:0]             rd_os_cnt = '0;
  logic                        arb_valid;
  logic                        arb_ready = 1'b0;
  logic [PD_W-1:0]             arb_pd;
  client_id_t                  arb_id;
  logic                        rsp_done = 1'b0;
  logic [OS_W-1:0]             os_inflight;
  logic                        idle;

  mcif_rd_wrr_arb dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_pd_i        (req_pd),
    .rd_weight_i     (rd_weight),
    .rd_os_cnt_i     (rd_os_cnt),
    .arb_valid_o     (arb_valid),
    .arb_ready_i     (arb_ready),
    .arb_pd_o        (arb_pd),
    .arb_id_o        (arb_id),
    .rsp_done_i      (rsp_done),
    .os_inflight_o   (os_inflight),
    .idle_o          (idle)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_CLIENTS-1:0] cfg_mask;
  int cfg_vld_pct, cfg_rdy_pct, cfg_done_pct, cfg_os;
  int weight [NUM_CLIENTS];

  int              m_credit [NUM_CLIENTS];
  int              m_ptr, m_os, m_id;
  bit              m_valid, m_idle;
  logic [PD_W-1:0] m_pd;
  int              dut_grants;

  typedef struct { int id; logic [PD_W-1:0] pd; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CLIENTS; i++) m_credit[i] = 0;
    m_ptr = 0; m_os = 0; m_id = 0; m_valid = 0; m_idle = 1; m_pd = '0;
    exp_q.delete();
  endtask

  // Apply the arbitration rules to the inputs of this cycle and advance the model by one edge.
  task automatic model_step();
    int win;
    bit grant, reload, idle_n;
    logic [NUM_CLIENTS-1:0] exp_rdy;
    check("arb_valid", arb_valid, m_valid);
    check("os_inflight", os_inflight, m_os);
    check("idle", idle, m_idle);
    if (m_valid) begin
      check("arb_id_held", arb_id, m_id);
      check("arb_pd_held", arb_pd, m_pd);
    end
    win = -1;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      int i;
      i = (m_ptr + k) % NUM_CLIENTS;
      if (win < 0 && req_valid[i] && m_credit[i] > 0) win = i;
    end
    grant  = (win >= 0) && (!m_valid || arb_ready) && (m_os < int'(rd_os_cnt));
    reload = (req_valid != '0) && (win < 0);
    exp_rdy = '0;
    if (grant) exp_rdy[win] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (req_ready != '0) dut_grants++;
    idle_n = (m_os == 0) && !m_valid && (req_valid == '0);
    if (reload) begin
      for (int i = 0; i < NUM_CLIENTS; i++) m_credit[i] = (weight[i] == 0) ? 1 : weight[i];
    end
    if (grant) begin
      m_credit[win] = m_credit[win] - 1;
      m_ptr   = (win + 1) % NUM_CLIENTS;
      m_valid = 1;
      m_id    = win;
      m_pd    = req_pd[win*PD_W +: PD_W];
      exp_q.push_back('{win, req_pd[win*PD_W +: PD_W]});
    end else if (arb_ready) begin
      m_valid = 0;
    end
    if (grant && !rsp_done) m_os = m_os + 1;
    else if (!grant && rsp_done && m_os > 0) m_os = m_os - 1;
    m_idle = idle_n;
  endtask

  task automatic cycle();
    @(posedge nvdla_core_clk);
    #1;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      req_valid[i] = cfg_mask[i] && (int'($urandom_range(99)) < cfg_vld_pct);
      req_pd[i*PD_W +: PD_W] = PD_W'({$urandom(), $urandom(), $urandom()});
      rd_weight[i*WT_W +: WT_W] = WT_W'(weight[i]);
    end
    arb_ready = (int'($urandom_range(99)) < cfg_rdy_pct);
    rsp_done  = (int'($urandom_range(99)) < cfg_done_pct);
    rd_os_cnt = OS_W'(cfg_os);
    #3;
    model_step();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    @(posedge nvdla_core_clk);
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    check("rst_arb_valid", arb_valid, 1'b0);
    check("rst_os_inflight", os_inflight, 0);
    check("rst_idle", idle, 1'b1);
    check("rst_arb_id", arb_id, 0);
    check("rst_arb_pd", arb_pd, 0);
    req_valid = '0; arb_ready = 1'b0; rsp_done = 1'b0;
    repeat (2) @(posedge nvdla_core_clk);
    #2;
    nvdla_core_rstn = 1'b1;
    model_reset();
  endtask

  // Every downstream handshake must match the oldest predicted grant.
  always @(negedge nvdla_core_clk) begin
    if (nvdla_core_rstn && arb_valid && arb_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: actual id=%0d required no transfer", arb_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_id", arb_id, mon_e.id);
        check("sb_pd", arb_pd, mon_e.pd);
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_CLIENTS; i++) weight[i] = 1;
    cfg_mask = '0; cfg_vld_pct = 100; cfg_rdy_pct = 100; cfg_done_pct = 0; cfg_os = 255;
    model_reset();
    do_reset();

    // Weights 3/1/2/1, four clients saturating: 7 grants + 1 reload per round.
    weight[0] = 3; weight[1] = 1; weight[2] = 2; weight[3] = 1;
    cfg_mask = 10'h00F; dut_grants = 0;
    run(24);
    check("wrr_grant_count", dut_grants, 21);

    // Outstanding limit of two with one client.
    do_reset();
    for (int i = 0; i < NUM_CLIENTS; i++) weight[i] = 4;
    cfg_os = 2; cfg_mask = 10'h020; dut_grants = 0;
    run(12);
    check("os_limit_grants", dut_grants, 2);
    cfg_done_pct = 100; run(1); cfg_done_pct = 0;
    run(8);
    check("os_after_done_grants", dut_grants, 3);
    check("os_after_done_count", os_inflight, 2);

    // Downstream stall with all clients valid.
    do_reset();
    for (int i = 0; i < NUM_CLIENTS; i++) weight[i] = 2;
    cfg_os = 255; cfg_mask = '1;
    run(3);
    cfg_rdy_pct = 0; dut_grants = 0;
    run(5);
    check("stall_grants", dut_grants, 0);
    cfg_rdy_pct = 100;
    run(1);
    check("unstall_same_cycle", dut_grants, 1);
    run(3);

    // Zero weight on a lone client: reload, grant, reload, grant...
    do_reset();
    weight[4] = 0; cfg_mask = 10'h010; dut_grants = 0;
    run(10);
    check("zero_weight_grants", dut_grants, 5);

    // Simultaneous grant and completion, then completions at zero.
    do_reset();
    weight[6] = 255; cfg_mask = 10'h040;
    run(6);
    cfg_done_pct = 100; run(1);
    cfg_done_pct = 0; cfg_mask = '0; run(1);
    check("grant_and_done", os_inflight, 5);
    cfg_done_pct = 100; run(8);
    cfg_done_pct = 0; run(1);
    check("done_saturates", os_inflight, 0);

    // Reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < NUM_CLIENTS; i++) weight[i] = 1;
    cfg_mask = '1;
    run(8);
    do_reset();
    run(3);
    check("post_reset_first_id", arb_id, 0);

    // Randomized traffic with shifting limits and weights.
    for (int p = 0; p < 6; p++) begin
      cfg_mask     = NUM_CLIENTS'($urandom());
      cfg_vld_pct  = 30 + int'($urandom_range(70));
      cfg_rdy_pct  = 20 + int'($urandom_range(80));
      cfg_done_pct = int'($urandom_range(60));
      cfg_os       = int'($urandom_range(6));
      for (int s = 0; s < 5; s++) begin
        for (int i = 0; i < NUM_CLIENTS; i++) weight[i] = int'($urandom_range(4));
        if (s == 3) cfg_os = int'($urandom_range(6));
        run(30);
      end
      if (p == 3) do_reset();
    end

    cfg_mask = '0; cfg_rdy_pct = 100; cfg_done_pct = 100;
    run(12);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
